stopwatch_timer: RTL and testbench

// - Start/stop stopwatch: counts clock cycles while running and holds the value while stopped.
// - Count wraps from MAX back to 0.
// - Standalone timing block; start/stop are single-cycle, synchronous control strobes from the host logic.
//

---
 rtl/stopwatch_timer.sv | 53 +++++
 tb/tb_stopwatch_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: start/stop elapsed-cycle counter that wraps from MAX to 0.
// Handshake: start and stop are single-cycle strobes sampled on the rising
// edge of clk. There is no ready/acknowledge. stop takes priority over start.
// Run/stop state is visible on o_dbg_running so checkers can bind to it.
module stopwatch_timer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  o_dbg_running
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(MAX);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_count;

    // Run/stop FSM and count register. The count advances only when the
    // state was already RUNNING before this edge, so a start strobe takes
    // effect one edge later. A stop strobe suppresses the increment on its own edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOPPED;
            r_count <= '0;
        end else begin
            if ((r_state == ST_RUNNING) && !stop) begin
                if (r_count == MAX_VAL) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (stop) begin
                r_state <= ST_STOPPED;
            end else if (start) begin
                r_state <= ST_RUNNING;
            end
        end
    end

    assign count         = r_count;
    assign o_dbg_running = (r_state == ST_RUNNING);

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: directed scenarios plus randomized start/stop
// traffic with occasional asynchronous resets, checked against a model.
module tb_stopwatch_timer;

    localparam int W   = 16;
    localparam int MAX = 99;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] count;
    logic         dbg_running;

    always #5 clk = ~clk;

    stopwatch_timer #(.DATA_WIDTH(W), .MAX(MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .count         (count),
        .o_dbg_running (dbg_running)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- behavioural model ----------------
    // Elapsed count is (increments so far) modulo MAX+1; it advances when
    // the watch was running before the edge and no stop arrives on it.
    int           m_count = 0;
    bit           m_run   = 1'b0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count = 0;
            m_run   = 1'b0;
        end else begin
            if (m_run && !stop) m_count = (m_count + 1) % (MAX + 1);
            if (stop)       m_run = 1'b0;
            else if (start) m_run = 1'b1;
        end
        exp_q.push_back(W'(m_count));
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cyc_count: no expectation queued, actual %0d", count);
            end else begin
                if (count !== exp_q[$]) begin
                    n_fail++;
                    $display("FAIL cyc_count: actual %0d required %0d at %0t", count, exp_q[$], $time);
                end
                exp_q.delete();
            end
            n_tests++;
            if (dbg_running !== m_run) begin
                n_fail++;
                $display("FAIL cyc_running: actual %0b required %0b at %0t", dbg_running, m_run, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Literal expectation: pins both the DUT and the model.
    task automatic check_lit(input string name, input int exp_cnt, input bit exp_run);
        n_tests++;
        if (count !== W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s: count actual %0d required %0d", name, count, exp_cnt);
        end
        n_tests++;
        if (m_count != exp_cnt) begin
            n_fail++;
            $display("FAIL %s_model: model count %0d required %0d", name, m_count, exp_cnt);
        end
        n_tests++;
        if (dbg_running !== exp_run) begin
            n_fail++;
            $display("FAIL %s_run: running actual %0b required %0b", name, dbg_running, exp_run);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        check_lit("reset_state", 0, 1'b0);

        // start, 5 idle, stop -> 5, then held.
        drive(1'b1, 1'b0);
        idle(5);
        drive(1'b0, 1'b1);
        check_lit("run5", 5, 1'b0);
        idle(10);
        check_lit("hold5", 5, 1'b0);

        // start and stop together from STOPPED -> stays stopped.
        drive(1'b1, 1'b1);
        idle(3);
        check_lit("start_stop_same", 5, 1'b0);

        // start, 10 idle, stop -> 10; resume 3 more -> 13.
        do_reset();
        check_lit("reset2", 0, 1'b0);
        drive(1'b1, 1'b0);
        idle(10);
        drive(1'b0, 1'b1);
        check_lit("run10", 10, 1'b0);
        drive(1'b1, 1'b0);
        idle(3);
        drive(1'b0, 1'b1);
        check_lit("resume13", 13, 1'b0);
        drive(1'b0, 1'b1);
        check_lit("stop_again", 13, 1'b0);

        // repeated start while running does not disturb the count.
        drive(1'b1, 1'b0);
        idle(2);
        drive(1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1);
        check_lit("restart_running", 18, 1'b0);

        // asynchronous reset mid-run clears at once, no restart after.
        drive(1'b1, 1'b0);
        idle(4);
        #2;
        reset = 1'b0;
        #1;
        check_lit("async_reset", 0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);
        check_lit("post_reset_idle", 0, 1'b0);

        // wrap: 100 increments -> 0, 110 -> 10.
        do_reset();
        drive(1'b1, 1'b0);
        idle(99);
        check_lit("at_max", 99, 1'b1);
        idle(1);
        check_lit("wrap0", 0, 1'b1);
        idle(10);
        drive(1'b0, 1'b1);
        check_lit("wrap10", 10, 1'b0);

        // start together with reset, release with start low -> stopped.
        start = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        check_lit("start_in_reset", 0, 1'b0);
        idle(3);
        check_lit("start_in_reset_idle", 0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 6)        drive(1'b1, 1'b0);
            else if (r < 9)   drive(1'b0, 1'b1);
            else if (r < 11)  drive(1'b1, 1'b1);
            else if (r == 199) begin
                #3;
                reset = 1'b0;
                #3;
                reset = 1'b1;
                @(posedge clk);
                #1;
            end else          drive(1'b0, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
